// File: rtl/riscv_tag_violation_ctrl_pkg.sv
// riscv_tag_violation_ctrl_pkg: cause-bit indices and FSM state type for the DIFT tag-violation controller
package riscv_tag_violation_ctrl_pkg;
  localparam int TAG_CAUSE_S1 = 0;
  localparam int TAG_CAUSE_S2 = 1;
  localparam int TAG_CAUSE_D  = 2;
  localparam int TAG_CAUSE_PC = 3;
  typedef enum logic [1:0] {TV_IDLE, TV_REQ, TV_HOLD} tag_viol_state_e;
endpackage

// File: rtl/riscv_tag_cause_enc.sv
// riscv_tag_cause_enc: combinational tag-check cause bitmap and violation flag
module riscv_tag_cause_enc (
  input  logic       valid_i,
  input  logic       enable_i,
  input  logic [3:0] check_i,
  input  logic [3:0] tag_i,
  output logic [3:0] cause_o,
  output logic       viol_o
);
  assign cause_o = check_i & tag_i;
  assign viol_o  = valid_i & enable_i & (|cause_o);
endmodule

// File: rtl/riscv_tag_violation_ctrl.sv
// riscv_tag_violation_ctrl: EX-stage DIFT tag-check sequencer with trap request, stall and violation log
module riscv_tag_violation_ctrl
  import riscv_tag_violation_ctrl_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int STICKY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             check_valid_i,
  input  logic             check_s1_i,
  input  logic             check_s2_i,
  input  logic             check_d_i,
  input  logic             check_pc_i,
  input  logic             tag_s1_i,
  input  logic             tag_s2_i,
  input  logic             tag_d_i,
  input  logic             tag_pc_i,
  input  logic [31:0]      pc_ex_i,
  input  logic [31:0]      instr_ex_i,
  input  logic             trap_ack_i,
  input  logic             clr_i,
  output logic             kill_wb_o,
  output logic             stall_o,
  output logic             trap_req_o,
  output logic             log_valid_o,
  output logic [31:0]      log_pc_o,
  output logic [31:0]      log_instr_o,
  output logic [3:0]       log_cause_o,
  output logic             log_ovf_o,
  output logic [CNT_W-1:0] viol_cnt_o
);
  tag_viol_state_e state_q;
  logic             stall_q, trap_q, lv_q, ovf_q, viol_raw, viol;
  logic [31:0]      pc_q, instr_q;
  logic [3:0]       cause_q, cause, chk, tag;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  assign chk[TAG_CAUSE_S1] = check_s1_i;
  assign chk[TAG_CAUSE_S2] = check_s2_i;
  assign chk[TAG_CAUSE_D]  = check_d_i;
  assign chk[TAG_CAUSE_PC] = check_pc_i;
  assign tag[TAG_CAUSE_S1] = tag_s1_i;
  assign tag[TAG_CAUSE_S2] = tag_s2_i;
  assign tag[TAG_CAUSE_D]  = tag_d_i;
  assign tag[TAG_CAUSE_PC] = tag_pc_i;
  riscv_tag_cause_enc u_enc (
    .valid_i (check_valid_i),
    .enable_i(enable_i),
    .check_i (chk),
    .tag_i   (tag),
    .cause_o (cause),
    .viol_o  (viol_raw)
  );
  // an instruction in EX while the trap is pending is already frozen, so it is not re-checked
  assign viol    = viol_raw & (state_q != TV_REQ);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TV_IDLE;
      stall_q <= 1'b0;
      trap_q  <= 1'b0;
      lv_q    <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      cause_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        TV_REQ: begin
          if (trap_ack_i) begin
            state_q <= (STICKY != 0) ? TV_HOLD : TV_IDLE;
            stall_q <= 1'b0;
            trap_q  <= 1'b0;
            if (STICKY == 0) begin
              lv_q    <= 1'b0;
              pc_q    <= '0;
              instr_q <= '0;
              cause_q <= '0;
              ovf_q   <= 1'b0;
            end
          end
        end
        default: begin
          if (viol) begin
            state_q <= TV_REQ;
            stall_q <= 1'b1;
            trap_q  <= 1'b1;
            // a same-cycle clear empties the log first, so the new violation becomes the first entry
            if (clr_i || !lv_q) begin
              lv_q    <= 1'b1;
              pc_q    <= pc_ex_i;
              instr_q <= instr_ex_i;
              cause_q <= cause;
              ovf_q   <= 1'b0;
              cnt_q   <= clr_i ? CNT_W'(1) : cnt_inc;
            end else begin
              ovf_q <= 1'b1;
              cnt_q <= cnt_inc;
            end
          end else if (clr_i) begin
            state_q <= TV_IDLE;
            lv_q    <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            cause_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end
  assign kill_wb_o   = viol;
  assign stall_o     = stall_q;
  assign trap_req_o  = trap_q;
  assign log_valid_o = lv_q;
  assign log_pc_o    = pc_q;
  assign log_instr_o = instr_q;
  assign log_cause_o = cause_q;
  assign log_ovf_o   = ovf_q;
  assign viol_cnt_o  = cnt_q;
endmodule
